// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and the ID/EX register layout.
// The regfile's write-through bypass is selected by ID_REGFILE_BYPASS_EN.
package core_pkg;

   localparam int XLEN      = 32;
   localparam int REG_COUNT = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      alu_op_e         alu_op;
      logic            alu_src;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            mem_to_reg;
      logic            branch;
      logic            jump;
      logic            illegal;
      logic            enable;
   } id_ex_t;

   // alt is funct7[5]: selects SUB over ADD and SRA over SRL
   function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-decode triple plus the writeback register-write port feeding id_stage.
interface id_stage_if;
   import core_pkg::*;

   logic [XLEN-1:0] IF_ID_PC;
   logic [XLEN-1:0] IF_ID_Instruction;
   logic            IF_ID_enable_out;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   modport master (
      output IF_ID_PC, IF_ID_Instruction, IF_ID_enable_out,
      output wb_reg_write, wb_rd, wb_data
   );

   modport slave (
      input IF_ID_PC, IF_ID_Instruction, IF_ID_enable_out,
      input wb_reg_write, wb_rd, wb_data
   );
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file, two async read ports, one sync write port, x0 reads as zero.
// Define ID_REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
module id_stage_regfile
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr_a,
   input  logic [4:0]      raddr_b,
   output logic [XLEN-1:0] rdata_a,
   output logic [XLEN-1:0] rdata_b
);

   logic [XLEN-1:0] regs [REG_COUNT];
   logic            write_ok;

   assign write_ok = we && (waddr != 5'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (write_ok) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
      rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
`ifdef ID_REGFILE_BYPASS_EN
      if (write_ok && raddr_a == waddr) rdata_a = wdata;
      if (write_ok && raddr_b == waddr) rdata_b = wdata;
`endif
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, register read, immediate generation, ID/EX register, load-use detect.
// Regfile write-through is enabled by defining ID_REGFILE_BYPASS_EN.
module id_stage
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            combined_stall,
   input  logic            flush,
   id_stage_if.slave       fetch,
   output logic            load_use_stall,
   output logic [XLEN-1:0] ID_EX_PC,
   output logic [XLEN-1:0] ID_EX_rs1_data,
   output logic [XLEN-1:0] ID_EX_rs2_data,
   output logic [XLEN-1:0] ID_EX_imm,
   output logic [4:0]      ID_EX_rs1,
   output logic [4:0]      ID_EX_rs2,
   output logic [4:0]      ID_EX_rd,
   output logic [2:0]      ID_EX_funct3,
   output logic [3:0]      ID_EX_alu_op,
   output logic            ID_EX_alu_src,
   output logic            ID_EX_mem_read,
   output logic            ID_EX_mem_write,
   output logic            ID_EX_reg_write,
   output logic            ID_EX_mem_to_reg,
   output logic            ID_EX_branch,
   output logic            ID_EX_jump,
   output logic            ID_EX_illegal,
   output logic            ID_EX_enable_out
);

   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] rf_rdata_a;
   logic [XLEN-1:0] rf_rdata_b;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            rs1_used;
   logic            rs2_used;
   id_ex_t          dec;
   id_ex_t          idex_q;

   assign inst = fetch.IF_ID_Instruction;

   id_stage_regfile u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (fetch.wb_reg_write),
      .waddr   (fetch.wb_rd),
      .wdata   (fetch.wb_data),
      .raddr_a (inst[19:15]),
      .raddr_b (inst[24:20]),
      .rdata_a (rf_rdata_a),
      .rdata_b (rf_rdata_b)
   );

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Unknown opcodes fall through with every side-effecting control left at zero
   always_comb begin
      dec          = '0;
      dec.pc       = fetch.IF_ID_PC;
      dec.rs1_data = rf_rdata_a;
      dec.rs2_data = rf_rdata_b;
      dec.rs1      = inst[19:15];
      dec.rs2      = inst[24:20];
      dec.rd       = inst[11:7];
      dec.funct3   = inst[14:12];
      dec.alu_op   = ALU_ADD;
      dec.enable   = 1'b1;
      rs1_used     = 1'b1;
      rs2_used     = 1'b0;
      case (inst[6:0])
         OPC_LUI: begin
            dec.imm       = imm_u;
            dec.alu_op    = ALU_PASS_B;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            rs1_used      = 1'b0;
         end
         OPC_AUIPC: begin
            dec.imm       = imm_u;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            rs1_used      = 1'b0;
         end
         OPC_JAL: begin
            dec.imm       = imm_j;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
            rs1_used      = 1'b0;
         end
         OPC_JALR: begin
            dec.imm       = imm_i;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm    = imm_b;
            dec.alu_op = ALU_SUB;
            dec.branch = 1'b1;
            rs2_used   = 1'b1;
         end
         OPC_LOAD: begin
            dec.imm        = imm_i;
            dec.alu_src    = 1'b1;
            dec.mem_read   = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
         end
         OPC_STORE: begin
            dec.imm       = imm_s;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            rs2_used      = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.imm       = imm_i;
            dec.alu_op    = alu_from_funct3(inst[14:12], (inst[14:12] == 3'b101) && inst[30]);
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_OP: begin
            dec.alu_op    = alu_from_funct3(inst[14:12], inst[30]);
            dec.reg_write = 1'b1;
            rs2_used      = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Flush outranks stall; an idle fetch only drops valid and leaves the payload held
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idex_q <= '0;
      end else if (flush || combined_stall) begin
         idex_q <= '0;
      end else if (fetch.IF_ID_enable_out) begin
         idex_q <= dec;
      end else begin
         idex_q.enable <= 1'b0;
      end
   end

   assign load_use_stall = idex_q.enable && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                           fetch.IF_ID_enable_out &&
                           (((idex_q.rd == inst[19:15]) && rs1_used) ||
                            ((idex_q.rd == inst[24:20]) && rs2_used));

   assign ID_EX_PC         = idex_q.pc;
   assign ID_EX_rs1_data   = idex_q.rs1_data;
   assign ID_EX_rs2_data   = idex_q.rs2_data;
   assign ID_EX_imm        = idex_q.imm;
   assign ID_EX_rs1        = idex_q.rs1;
   assign ID_EX_rs2        = idex_q.rs2;
   assign ID_EX_rd         = idex_q.rd;
   assign ID_EX_funct3     = idex_q.funct3;
   assign ID_EX_alu_op     = idex_q.alu_op;
   assign ID_EX_alu_src    = idex_q.alu_src;
   assign ID_EX_mem_read   = idex_q.mem_read;
   assign ID_EX_mem_write  = idex_q.mem_write;
   assign ID_EX_reg_write  = idex_q.reg_write;
   assign ID_EX_mem_to_reg = idex_q.mem_to_reg;
   assign ID_EX_branch     = idex_q.branch;
   assign ID_EX_jump       = idex_q.jump;
   assign ID_EX_illegal    = idex_q.illegal;
   assign ID_EX_enable_out = idex_q.enable;

endmodule
